// File: rtl/fifo_pkg.sv
// Shared defaults and control-state encoding for the FIFO read-side streamer.
package fifo_pkg;

  localparam int unsigned DWIDTH_DEF = 8;
  localparam int unsigned BURST_DEF  = 4;

  // State tracks words owned by the streamer: buffered plus in flight.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FULL2 = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for fifo_rd_stream.
interface fifo_rd_stream_if #(
  parameter int unsigned DWIDTH = fifo_pkg::DWIDTH_DEF
);

  logic              pop;
  logic              empty;
  logic [DWIDTH-1:0] rdata;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_last;
  logic [7:0]        beat_cnt;

  modport master (
    output pop, out_valid, out_data, out_last, beat_cnt,
    input  empty, rdata, flush, out_ready
  );

  modport slave (
    input  pop, out_valid, out_data, out_last, beat_cnt,
    output empty, rdata, flush, out_ready
  );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer; reset is synchronous and active-low, and zeroes the data.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data,
  output logic [1:0]        occ
);

  logic [DWIDTH-1:0] ent0_q, ent0_d;
  logic [DWIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]        occ_q, occ_d;

  // ent0 is always the head; a read shifts ent1 forward.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    unique case ({wr_en, rd_en})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = wr_data;
        else               ent1_d = wr_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = wr_data;
        end else begin
          ent0_d = wr_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign rd_data = ent0_q;
  assign occ     = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops a 1-cycle-latency FIFO into a 2-entry buffer and presents it as a burst-framed stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned BURST  = BURST_DEF
) (
  input logic              rclk,
  input logic              reset_L,
  fifo_rd_stream_if.master bus
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

  state_e            state_q, state_d;
  logic              infl_q;
  logic [7:0]        beat_q, beat_d;
  logic [1:0]        occ;
  logic [DWIDTH-1:0] head;
  logic              accept;
  logic              pop_w;
  logic              buf_rst_n;

  assign accept = (occ != 2'd0) && bus.out_ready;
  assign pop_w  = reset_L && !bus.empty && !bus.flush && ((state_q != FULL2) || accept);

  // Flush clears the buffer through its synchronous reset, which also drops the returning word.
  assign buf_rst_n = reset_L && !bus.flush;

  skid_buf2 #(.DWIDTH(DWIDTH)) u_buf (
    .clock   (rclk),
    .reset   (buf_rst_n),
    .wr_en   (infl_q),
    .wr_data (bus.rdata),
    .rd_en   (accept),
    .rd_data (head),
    .occ     (occ)
  );

  always_comb begin
    state_d = state_q;
    if (pop_w && !accept)      state_d = (state_q == IDLE)  ? FILL : FULL2;
    else if (!pop_w && accept) state_d = (state_q == FULL2) ? FILL : IDLE;
    beat_d = beat_q;
    if (accept) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 8'd1;
  end

  always_ff @(posedge rclk) begin
    if (!reset_L || bus.flush) begin
      state_q <= IDLE;
      infl_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= pop_w;
      beat_q  <= beat_d;
    end
  end

  assign bus.pop       = pop_w;
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = head;
  assign bus.out_last  = (occ != 2'd0) && (beat_q == LAST_BEAT);
  assign bus.beat_cnt  = beat_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: BURST=4 and BURST=2 instances share one FIFO model.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;
  localparam int B4 = 4;
  localparam int B2 = 2;

  typedef struct {
    logic [DW-1:0] d;
    int            avail;
  } ent_t;

  logic          rclk = 1'b0;
  logic          reset_L;
  logic          empty;
  logic          flush;
  logic          out_ready;
  logic [DW-1:0] rdata;

  fifo_rd_stream_if #(.DWIDTH(DW)) bus4 ();
  fifo_rd_stream_if #(.DWIDTH(DW)) bus2 ();

  assign bus4.empty = empty;     assign bus2.empty = empty;
  assign bus4.flush = flush;     assign bus2.flush = flush;
  assign bus4.rdata = rdata;     assign bus2.rdata = rdata;
  assign bus4.out_ready = out_ready;
  assign bus2.out_ready = out_ready;

  fifo_rd_stream #(.DWIDTH(DW), .BURST(B4)) dut4 (
    .rclk    (rclk),
    .reset_L (reset_L),
    .bus     (bus4.master)
  );

  fifo_rd_stream #(.DWIDTH(DW), .BURST(B2)) dut2 (
    .rclk    (rclk),
    .reset_L (reset_L),
    .bus     (bus2.master)
  );

  always #5 rclk = ~rclk;

  int            tests = 0;
  int            fails = 0;
  int            cnum = 0;
  int            pop_cnt = 0;
  int            first_pop = -1;
  logic [DW-1:0] src_q[$];
  ent_t          exp_q[$];
  int            xfer_cyc[$];
  logic          pend_v = 1'b0;
  logic [DW-1:0] pend_d = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cnum);
    end
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle(input logic rdy, input logic fl, input logic rst);
    logic exp_valid, exp_pop;
    int   sz;
    cnum++;
    out_ready = rdy;
    flush     = fl;
    reset_L   = ~rst;
    empty     = (src_q.size() == 0);
    rdata     = pend_v ? pend_d : 8'($urandom);
    sz        = exp_q.size();
    exp_valid = (sz > 0) && (exp_q[0].avail <= cnum);
    exp_pop   = !rst && !fl && !empty && ((sz < 2) || ((sz == 2) && exp_valid && rdy));
    @(negedge rclk); #1;
    chk("pop", bus4.pop, exp_pop);
    chk("pop_b2", bus2.pop, exp_pop);
    chk("out_valid", bus4.out_valid, exp_valid);
    pend_v = 1'b0;
    if (bus4.pop && src_q.size() > 0) begin
      pend_d = src_q.pop_front();
      pend_v = 1'b1;
      exp_q.push_back('{d: pend_d, avail: cnum + 2});
      pop_cnt++;
      if (first_pop < 0) first_pop = cnum;
    end
    if (fl || rst) exp_q.delete();
    @(posedge rclk); #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && n < 100) begin
      cycle(1'b1, 1'b0, 1'b0);
      n++;
    end
    chk({tag, "_drained"}, exp_q.size() + src_q.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, bus4.out_valid, 0);
    chk({tag, "_data"},  bus4.out_data, 0);
    chk({tag, "_last"},  bus4.out_last, 0);
    chk({tag, "_beat"},  bus4.beat_cnt, 0);
  endtask

  // Monitor: pops the scoreboard on every accepted beat and tracks burst framing.
  initial begin
    ent_t          e;
    logic          pv, pr, pf, prst;
    logic [DW-1:0] pd;
    int            b4, b2;
    pv = 1'b0; pr = 1'b0; pf = 1'b0; prst = 1'b1; pd = '0; b4 = 0; b2 = 0;
    forever begin
      @(negedge rclk);
      if (pf || !prst) begin
        chk("beat_after_clear", bus4.beat_cnt, 0);
        chk("beat_after_clear_b2", bus2.beat_cnt, 0);
      end
      if (pv && !pr && !pf && prst) begin
        chk("hold_valid", bus4.out_valid, 1);
        chk("hold_data", bus4.out_data, pd);
      end
      chk("last", bus4.out_last, bus4.out_valid && (b4 == B4 - 1));
      chk("last_b2", bus2.out_last, bus2.out_valid && (b2 == B2 - 1));
      if (bus4.out_valid) chk("beat", bus4.beat_cnt, b4);
      if (bus2.out_valid) chk("beat_b2", bus2.beat_cnt, b2);
      if (bus4.out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_beat: got data %0h, expected no beat (cycle %0d)",
                   bus4.out_data, cnum);
        end else begin
          e = exp_q.pop_front();
          chk("data", bus4.out_data, e.d);
          chk("data_b2", bus2.out_data, e.d);
        end
        xfer_cyc.push_back(cnum);
        b4 = (b4 == B4 - 1) ? 0 : b4 + 1;
        b2 = (b2 == B2 - 1) ? 0 : b2 + 1;
      end
      if (flush || !reset_L) begin
        b4 = 0;
        b2 = 0;
      end
      pv = bus4.out_valid; pr = out_ready; pf = flush; prst = reset_L; pd = bus4.out_data;
    end
  end

  initial begin
    logic rdy, fl, rs;
    reset_L = 1'b0; flush = 1'b0; out_ready = 1'b0; empty = 1'b1; rdata = '0;
    @(posedge rclk); #1;
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    chk_zero_outputs("reset");
    chk("reset_pop", bus4.pop, 0);

    // Preloaded 1..8, downstream always ready.
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    pop_cnt = 0; first_pop = -1; xfer_cyc.delete();
    repeat (12) cycle(1'b1, 1'b0, 1'b0);
    chk("A_pops", pop_cnt, 8);
    chk("A_beats", xfer_cyc.size(), 8);
    if (xfer_cyc.size() == 8) begin
      chk("A_latency", xfer_cyc[0], first_pop + 2);
      chk("A_back_to_back", xfer_cyc[7] - xfer_cyc[0], 7);
    end

    // Same preload with downstream stalled for 10 cycles.
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    pop_cnt = 0; xfer_cyc.delete();
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    chk("B_pops", pop_cnt, 2);
    chk("B_hold_data", bus4.out_data, 8'h01);
    repeat (12) cycle(1'b1, 1'b0, 1'b0);
    chk("B_beats", xfer_cyc.size(), 8);
    if (xfer_cyc.size() == 8) chk("B_no_gaps", xfer_cyc[7] - xfer_cyc[0], 7);

    // Flush with one word buffered, one in flight and beat_cnt=2.
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) src_q.push_back(8'(8'h40 + i));
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    chk("D_beat_before_flush", bus4.beat_cnt, 2);
    xfer_cyc.delete();
    cycle(1'b0, 1'b1, 1'b0);
    chk("D_valid_after_flush", bus4.out_valid, 0);
    chk("D_beat_after_flush", bus4.beat_cnt, 0);
    drain("D");
    chk("D_beats_after_flush", xfer_cyc.size(), 6);

    // One-cycle reset in the middle of a burst.
    for (int i = 0; i < 10; i++) src_q.push_back(8'(8'h80 + i));
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    chk_zero_outputs("E_reset");
    drain("E");

    // Randomized traffic, with a stretch of alternating ready and a full source.
    for (int i = 0; i < 600; i++) begin
      if ((i >= 300 && i < 340) || $urandom_range(0, 99) < 40) src_q.push_back(8'($urandom));
      rdy = (i >= 300 && i < 340) ? ((i % 2) == 0) : ($urandom_range(0, 99) < 60);
      fl  = (i < 300 || i >= 340) && ($urandom_range(0, 99) < 3);
      rs  = (i < 300 || i >= 340) && ($urandom_range(0, 199) == 0);
      cycle(rdy, fl, rs);
    end
    drain("C");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
